// File: rtl/led_pwm_pkg.sv
// Shared field positions and per-channel configuration type for the LED PWM block.
`timescale 1ns/1ps
package led_pwm_pkg;

  localparam int DUTY_BITS      = 8;
  localparam int TIM_FIELD_BITS = 16;

  localparam int CTRL_EN_LSB  = 0;
  localparam int CTRL_BLK_LSB = 8;
  localparam int CTRL_FRC_LSB = 16;
  localparam int CTRL_RUN_BIT = 31;

  localparam int TIM_PSC_LSB  = 0;
  localparam int TIM_HALF_LSB = 16;

  localparam int STAT_CNT_LSB    = 0;
  localparam int STAT_PHASE_BIT  = 8;
  localparam int STAT_FRAMES_LSB = 16;

  typedef struct packed {
    logic                 en;
    logic                 blk;
    logic                 frc;
    logic [DUTY_BITS-1:0] duty;
  } led_cfg_t;

endpackage

// File: rtl/led_pwm_ctrl_if.sv
// Register-file side of the LED PWM block: three control words in, one status word out.
`timescale 1ns/1ps
interface led_pwm_ctrl_if;

  logic [31:0] ctrl_i;
  logic [31:0] duty_i;
  logic [31:0] timing_i;
  logic [31:0] status_o;

  modport master (output ctrl_i, output duty_i, output timing_i, input status_o);
  modport slave  (input ctrl_i, input duty_i, input timing_i, output status_o);

endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: frame-synchronous shadow configuration, duty compare and output flop.
`timescale 1ns/1ps
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                load,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic                phase,
  input  led_cfg_t            cfg_in,
  output logic                led
);

  led_cfg_t            cfg_sh;
  logic [PWM_BITS-1:0] duty_w;
  logic                led_next;

  assign duty_w   = PWM_BITS'(cfg_sh.duty);
  assign led_next = cfg_sh.frc | (cfg_sh.en & (cnt < duty_w) & (~cfg_sh.blk | phase));

  // NOTE: the shadow is a handful of flops, not a memory, so it is reset with everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_sh <= '0;
      led    <= 1'b0;
    end else begin
      if (load) cfg_sh <= cfg_in;
      led <= run & led_next;
    end
  end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Per-LED PWM dimmer/blinker: shared prescaler, PWM and blink counters feeding NUM_LEDS channels.
`timescale 1ns/1ps
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int NUM_LEDS = 4,
  parameter int PWM_BITS = 8
) (
  input  logic                axi_aclk,
  input  logic                axi_reset,
  led_pwm_ctrl_if.slave       regs,
  output logic [NUM_LEDS-1:0] led
);

  logic [TIM_FIELD_BITS-1:0] psc;
  logic [TIM_FIELD_BITS-1:0] psc_max;
  logic [TIM_FIELD_BITS-1:0] half;
  logic [TIM_FIELD_BITS-1:0] fcnt;
  logic [15:0]               frames;
  logic [PWM_BITS-1:0]       cnt;
  logic                      phase;
  logic                      run;
  logic                      tick;
  logic                      frame;
  logic [31:0]               status_word;
  logic                      unused_bits;

  assign run     = regs.ctrl_i[CTRL_RUN_BIT];
  assign psc_max = regs.timing_i[TIM_PSC_LSB +: TIM_FIELD_BITS];
  assign half    = regs.timing_i[TIM_HALF_LSB +: TIM_FIELD_BITS];
  assign tick    = run && (psc >= psc_max);
  assign frame   = tick && (cnt == '1);

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      psc    <= '0;
      cnt    <= '0;
      fcnt   <= '0;
      phase  <= 1'b0;
      frames <= '0;
    end else if (!run) begin
      psc   <= '0;
      cnt   <= '0;
      fcnt  <= '0;
      phase <= 1'b0;
    end else begin
      if (tick) begin
        psc <= '0;
        cnt <= cnt + PWM_BITS'(1);
      end else begin
        psc <= psc + TIM_FIELD_BITS'(1);
      end
      if (frame) begin
        frames <= frames + 16'd1;
        if (fcnt >= half) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + TIM_FIELD_BITS'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_cfg_t cfg_in;
    assign cfg_in = '{en:   regs.ctrl_i[CTRL_EN_LSB + i],
                      blk:  regs.ctrl_i[CTRL_BLK_LSB + i],
                      frc:  regs.ctrl_i[CTRL_FRC_LSB + i],
                      duty: regs.duty_i[DUTY_BITS*i +: DUTY_BITS]};

    // Shadows follow the inputs continuously while stopped, so the first running frame is current.
    led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk    (axi_aclk),
      .rst    (axi_reset),
      .run    (run),
      .load   (frame || !run),
      .cnt    (cnt),
      .phase  (phase),
      .cfg_in (cfg_in),
      .led    (led[i])
    );
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    status_word                                  = '0;
    status_word[STAT_CNT_LSB +: DUTY_BITS]       = DUTY_BITS'(cnt);
    status_word[STAT_PHASE_BIT]                  = phase;
    status_word[STAT_FRAMES_LSB +: 16]           = frames;
  end

  assign regs.status_o = status_word;

  // Control bits for channels beyond NUM_LEDS are intentionally ignored.
  assign unused_bits = ^{regs.ctrl_i, regs.duty_i};

endmodule
